bsg_manycore_link_sif_edge_buffer: RTL and testbench
====================================================

Name: bsg_manycore_link_sif_edge_buffer

Overview:
- Registered elastic buffer stage for one manycore link endpoint, placed between the horizontal E or W edge link of the BlackParrot mesh row and the adjacent pod array edge.
- Buffers the forward (request) and reverse (response) networks independently, each in its own els_p-deep FIFO.
- Cuts every combinational valid/ready path across the boundary.
- Provides a per-channel saturating packet counter and a registered link-idle flag for drain/quiesce sequencing.

Parameters:
- fwd_width_p, 64, forward packet width in bits (manycore fwd packet width for the chosen addr/data/cord widths).
- rev_width_p, 40, reverse packet width in bits.
- els_p, 2, FIFO depth per channel; must be at least 2.
- count_width_p, 16, width of each packet counter.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  synchronous, active-low reset.
- fwd_v_i  in  1  forward packet valid from the mesh side.
- fwd_data_i  in  fwd_width_p  forward packet from the mesh side.
- fwd_ready_o  out  1  forward buffer can accept a packet.
- fwd_v_o  out  1  forward packet valid toward the pod side.
- fwd_data_o  out  fwd_width_p  forward packet at the FIFO head.
- fwd_ready_i  in  1  pod side accepts the forward packet.
- rev_v_i  in  1  reverse packet valid from the pod side.
- rev_data_i  in  rev_width_p  reverse packet from the pod side.
- rev_ready_o  out  1  reverse buffer can accept a packet.
- rev_v_o  out  1  reverse packet valid toward the mesh side.
- rev_data_o  out  rev_width_p  reverse packet at the FIFO head.
- rev_ready_i  in  1  mesh side accepts the reverse packet.
- fwd_count_o  out  count_width_p  forward packets dequeued since reset (saturating).
- rev_count_o  out  count_width_p  reverse packets dequeued since reset (saturating).
- idle_o  out  1  both FIFOs empty, registered.

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is synchronous and active-low; all state changes only on the rising edge of clk_i.
- Reset values, while reset_n_i=0 and in the first cycle after release:
  - fwd_ready_o=1 and rev_ready_o=1 in that first cycle; both are 0 while reset_n_i=0.
  - fwd_v_o=0, rev_v_o=0.
  - fwd_data_o=0, rev_data_o=0; all storage entries are cleared.
  - fwd_count_o=0, rev_count_o=0.
  - idle_o=0 while in reset, 1 in the first cycle after release.
- Each channel is a circular FIFO with read and write pointers of clog2(els_p) bits plus an occupancy count of 0..els_p. Pointers wrap from els_p-1 to 0, including non-power-of-two els_p.
- Enqueue happens when v_i & ready_o. Dequeue happens when v_o & ready_i.
- ready_o = (count != els_p). It is a function of registered state only and never depends on ready_i, so there is no ready-to-ready combinational path.
- v_o = (count != 0). data_o is the head entry, driven from a register or storage read with no input-to-output path.
- Latency: a packet enqueued in cycle t is visible at v_o in cycle t+1; there is no fall-through when empty.
- Simultaneous enqueue and dequeue with 0 < count < els_p: count is unchanged and both pointers advance.
- When full, ready_o=0, so an enqueue cannot occur and a dequeue frees one slot. ready_o rises in the next cycle.
- When empty, a dequeue cannot occur; an enqueue raises v_o in the next cycle.
- v_i asserted while ready_o=0: the packet is not taken, and the sender must hold it (valid/ready contract). Nothing is dropped or duplicated.
- Packet order is strictly preserved per channel. The two channels are fully independent and never stall each other.
- Counters: each increments by 1 on its channel's dequeue and saturates at 2^count_width_p-1 (no wrap).
- idle_o is registered: it equals (fwd count==0 && rev count==0) as computed from the next-state values, so it is a registered flag that is not late relative to the FIFO state.
- Reset asserted mid-operation: all buffered packets are discarded, counters clear, and outputs take their reset values on the next edge.

Test Plan:
- Reset release: hold reset_n_i=0 for 3 cycles, then release → all v_o=0, counts=0; idle_o=1 and both ready_o=1 in the first cycle after release.
- Single packet: fwd_v_i=1 with fwd_data_i=64'hDEAD_BEEF_0000_0001 for one cycle, fwd_ready_i=1 → fwd_v_o=1 with matching data exactly one cycle later; fwd_count_o=1; idle_o returns to 1 afterward.
- Backpressure fill: rev_ready_i=0, push 3 rev packets A,B,C with els_p=2 → rev_ready_o=0 after 2 accepted; C is held by the sender. Release rev_ready_i → order A,B,C out; rev_count_o=3.
- Streaming: continuous fwd_v_i with fwd_ready_i=1 for 100 cycles → 1 packet/cycle after 1-cycle fill; fwd_count_o=100; no gaps or reordering.
- Random stall, both channels: 10k cycles of random valid/ready, scoreboard compare → zero mismatches; fwd and rev traffic independent.
- Saturation and mid-flight reset:
  - count_width_p=4: 20 dequeues → fwd_count_o=15.
  - Assert reset with 2 entries buffered → v_o=0 next cycle, and no stale packet after release.

Source files
------------

// File: rtl/bsg_manycore_link_sif_edge_buffer_if.sv
// Valid/ready bundle for one manycore link edge buffer: forward and reverse
// packet channels plus the per-channel packet counters and the link-idle flag.
interface bsg_manycore_link_sif_edge_buffer_if #(
  parameter int fwd_width_p   = 64,
  parameter int rev_width_p   = 40,
  parameter int count_width_p = 16
);
  logic                     fwd_v_i;
  logic [fwd_width_p-1:0]   fwd_data_i;
  logic                     fwd_ready_o;
  logic                     fwd_v_o;
  logic [fwd_width_p-1:0]   fwd_data_o;
  logic                     fwd_ready_i;

  logic                     rev_v_i;
  logic [rev_width_p-1:0]   rev_data_i;
  logic                     rev_ready_o;
  logic                     rev_v_o;
  logic [rev_width_p-1:0]   rev_data_o;
  logic                     rev_ready_i;

  logic [count_width_p-1:0] fwd_count_o;
  logic [count_width_p-1:0] rev_count_o;
  logic                     idle_o;

  modport slave (
    input  fwd_v_i, fwd_data_i, fwd_ready_i,
    input  rev_v_i, rev_data_i, rev_ready_i,
    output fwd_ready_o, fwd_v_o, fwd_data_o,
    output rev_ready_o, rev_v_o, rev_data_o,
    output fwd_count_o, rev_count_o, idle_o
  );

  modport master (
    output fwd_v_i, fwd_data_i, fwd_ready_i,
    output rev_v_i, rev_data_i, rev_ready_i,
    input  fwd_ready_o, fwd_v_o, fwd_data_o,
    input  rev_ready_o, rev_v_o, rev_data_o,
    input  fwd_count_o, rev_count_o, idle_o
  );
endinterface

// File: rtl/bsg_manycore_link_sif_edge_buffer.sv
// Registered elastic buffer between a mesh-row E/W edge link and the pod array edge.
// Each network gets its own circular FIFO; every output is a function of registered state.
module bsg_manycore_link_sif_edge_fifo #(
  parameter int width_p       = 64,
  parameter int els_p         = 2,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     live_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_i,
  output logic [count_width_p-1:0] count_o,
  output logic                     empty_next_o
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int occ_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]       mem_r [els_p];
  logic [ptr_w_lp-1:0]      rptr_r, wptr_r;
  logic [occ_w_lp-1:0]      occ_r, occ_n;
  logic [count_width_p-1:0] pkt_r;
  logic                     enq, deq;

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // live_i holds ready low until the first clock after reset release.
  assign ready_o      = live_i & (occ_r != occ_w_lp'(els_p));
  assign v_o          = (occ_r != '0);
  assign data_o       = mem_r[rptr_r];
  assign count_o      = pkt_r;
  assign enq          = v_i & ready_o;
  assign deq          = v_o & ready_i;
  assign empty_next_o = (occ_n == '0);

  always_comb begin
    occ_n = occ_r;
    if (enq && !deq)
      occ_n = occ_r + occ_w_lp'(1);
    else if (deq && !enq)
      occ_n = occ_r - occ_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      occ_r  <= '0;
      pkt_r  <= '0;
      for (int i = 0; i < els_p; i++)
        mem_r[i] <= '0;
    end else begin
      if (enq) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= bump(wptr_r);
      end
      if (deq) begin
        rptr_r <= bump(rptr_r);
        if (pkt_r != '1)
          pkt_r <= pkt_r + count_width_p'(1);
      end
      occ_r <= occ_n;
    end
  end
endmodule

module bsg_manycore_link_sif_edge_buffer #(
  parameter int fwd_width_p   = 64,
  parameter int rev_width_p   = 40,
  parameter int els_p         = 2,
  parameter int count_width_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_manycore_link_sif_edge_buffer_if.slave link
);
  logic live_r;
  logic idle_r;
  logic fwd_empty_n;
  logic rev_empty_n;

  // idle is computed from next-state occupancy so it tracks the FIFOs without a cycle of lag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      live_r <= 1'b0;
      idle_r <= 1'b0;
    end else begin
      live_r <= 1'b1;
      idle_r <= fwd_empty_n & rev_empty_n;
    end
  end

  assign link.idle_o = idle_r;

  bsg_manycore_link_sif_edge_fifo #(
    .width_p      (fwd_width_p),
    .els_p        (els_p),
    .count_width_p(count_width_p)
  ) fwd_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .live_i      (live_r),
    .v_i         (link.fwd_v_i),
    .data_i      (link.fwd_data_i),
    .ready_o     (link.fwd_ready_o),
    .v_o         (link.fwd_v_o),
    .data_o      (link.fwd_data_o),
    .ready_i     (link.fwd_ready_i),
    .count_o     (link.fwd_count_o),
    .empty_next_o(fwd_empty_n)
  );

  bsg_manycore_link_sif_edge_fifo #(
    .width_p      (rev_width_p),
    .els_p        (els_p),
    .count_width_p(count_width_p)
  ) rev_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .live_i      (live_r),
    .v_i         (link.rev_v_i),
    .data_i      (link.rev_data_i),
    .ready_o     (link.rev_ready_o),
    .v_o         (link.rev_v_o),
    .data_o      (link.rev_data_o),
    .ready_i     (link.rev_ready_i),
    .count_o     (link.rev_count_o),
    .empty_next_o(rev_empty_n)
  );
endmodule

// File: tb/tb_bsg_manycore_link_sif_edge_buffer.sv
// Directed and constrained-random checks of the edge buffer: a default instance
// (els_p=2, 16-bit counters) and a small one (els_p=3, 4-bit counters).
module tb_bsg_manycore_link_sif_edge_buffer;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   exp_fwd_cnt;
  int   exp_rev_cnt;

  logic [63:0] fq[$];
  logic [39:0] rq[$];
  logic [63:0] sq[$];

  bsg_manycore_link_sif_edge_buffer_if #(.fwd_width_p(64), .rev_width_p(40), .count_width_p(16)) lk();
  bsg_manycore_link_sif_edge_buffer_if #(.fwd_width_p(64), .rev_width_p(40), .count_width_p(4))  ls();

  bsg_manycore_link_sif_edge_buffer #(
    .fwd_width_p(64), .rev_width_p(40), .els_p(2), .count_width_p(16)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .link(lk.slave)
  );

  bsg_manycore_link_sif_edge_buffer #(
    .fwd_width_p(64), .rev_width_p(40), .els_p(3), .count_width_p(4)
  ) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .link(ls.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bounded run of model-checked traffic on the default instance.
  task automatic traffic(input int n, input int fv, input int fr, input int rv, input int rr);
    bit fenq, fdeq, renq, rdeq;
    for (int c = 0; c < n; c++) begin
      chk("fwd_v", 64'(lk.fwd_v_o), 64'(fq.size() != 0));
      chk("fwd_ready", 64'(lk.fwd_ready_o), 64'(fq.size() < 2));
      chk("rev_v", 64'(lk.rev_v_o), 64'(rq.size() != 0));
      chk("rev_ready", 64'(lk.rev_ready_o), 64'(rq.size() < 2));
      chk("idle", 64'(lk.idle_o), 64'(fq.size() == 0 && rq.size() == 0));
      chk("fwd_count", 64'(lk.fwd_count_o), 64'(exp_fwd_cnt));
      chk("rev_count", 64'(lk.rev_count_o), 64'(exp_rev_cnt));
      if (!lk.fwd_v_i && $urandom_range(99, 0) < fv) begin
        lk.fwd_v_i    = 1'b1;
        lk.fwd_data_i = {$urandom, $urandom};
      end
      if (!lk.rev_v_i && $urandom_range(99, 0) < rv) begin
        lk.rev_v_i    = 1'b1;
        lk.rev_data_i = {8'($urandom), $urandom};
      end
      lk.fwd_ready_i = ($urandom_range(99, 0) < fr);
      lk.rev_ready_i = ($urandom_range(99, 0) < rr);
      fenq = lk.fwd_v_i && (fq.size() < 2);
      fdeq = lk.fwd_ready_i && (fq.size() != 0);
      renq = lk.rev_v_i && (rq.size() < 2);
      rdeq = lk.rev_ready_i && (rq.size() != 0);
      if (fdeq) begin
        chk("fwd_data", lk.fwd_data_o, fq.pop_front());
        exp_fwd_cnt++;
      end
      if (rdeq) begin
        chk("rev_data", 64'(lk.rev_data_o), 64'(rq.pop_front()));
        exp_rev_cnt++;
      end
      if (fenq) fq.push_back(lk.fwd_data_i);
      if (renq) rq.push_back(lk.rev_data_i);
      step();
      if (fenq) lk.fwd_v_i = 1'b0;
      if (renq) lk.rev_v_i = 1'b0;
    end
  endtask

  initial begin
    logic [39:0] bp [3];
    int k, sent;
    bit acc;
    n_checks = 0;
    n_errors = 0;
    exp_fwd_cnt = 0;
    exp_rev_cnt = 0;
    reset_n = 1'b0;
    lk.fwd_v_i = 0; lk.fwd_data_i = '0; lk.fwd_ready_i = 0;
    lk.rev_v_i = 0; lk.rev_data_i = '0; lk.rev_ready_i = 0;
    ls.fwd_v_i = 0; ls.fwd_data_i = '0; ls.fwd_ready_i = 0;
    ls.rev_v_i = 0; ls.rev_data_i = '0; ls.rev_ready_i = 0;

    // Reset held for three cycles, then released.
    repeat (3) step();
    chk("rst_fwd_ready", 64'(lk.fwd_ready_o), 64'd0);
    chk("rst_rev_ready", 64'(lk.rev_ready_o), 64'd0);
    chk("rst_idle", 64'(lk.idle_o), 64'd0);
    chk("rst_fwd_v", 64'(lk.fwd_v_o), 64'd0);
    reset_n = 1'b1;
    step();
    chk("rel_fwd_ready", 64'(lk.fwd_ready_o), 64'd1);
    chk("rel_rev_ready", 64'(lk.rev_ready_o), 64'd1);
    chk("rel_idle", 64'(lk.idle_o), 64'd1);
    chk("rel_fwd_v", 64'(lk.fwd_v_o), 64'd0);
    chk("rel_rev_v", 64'(lk.rev_v_o), 64'd0);
    chk("rel_fwd_data", lk.fwd_data_o, 64'd0);
    chk("rel_rev_data", 64'(lk.rev_data_o), 64'd0);
    chk("rel_fwd_count", 64'(lk.fwd_count_o), 64'd0);
    chk("rel_rev_count", 64'(lk.rev_count_o), 64'd0);

    // Single forward packet: visible one cycle after enqueue.
    lk.fwd_v_i = 1'b1;
    lk.fwd_data_i = 64'hDEAD_BEEF_0000_0001;
    lk.fwd_ready_i = 1'b1;
    step();
    lk.fwd_v_i = 1'b0;
    chk("single_v", 64'(lk.fwd_v_o), 64'd1);
    chk("single_data", lk.fwd_data_o, 64'hDEAD_BEEF_0000_0001);
    chk("single_idle_busy", 64'(lk.idle_o), 64'd0);
    chk("single_rev_v", 64'(lk.rev_v_o), 64'd0);
    step();
    chk("single_count", 64'(lk.fwd_count_o), 64'd1);
    chk("single_v_after", 64'(lk.fwd_v_o), 64'd0);
    chk("single_idle_back", 64'(lk.idle_o), 64'd1);
    exp_fwd_cnt = 1;
    lk.fwd_ready_i = 1'b0;

    // Reverse backpressure: two accepted, third held by the sender.
    bp[0] = 40'hA0_0000_00AA;
    bp[1] = 40'hB0_0000_00BB;
    bp[2] = 40'hC0_0000_00CC;
    lk.rev_ready_i = 1'b0;
    lk.rev_v_i = 1'b1;
    lk.rev_data_i = bp[0];
    step();
    chk("bp_ready_1", 64'(lk.rev_ready_o), 64'd1);
    lk.rev_data_i = bp[1];
    step();
    chk("bp_ready_full", 64'(lk.rev_ready_o), 64'd0);
    chk("bp_head", 64'(lk.rev_data_o), 64'(bp[0]));
    lk.rev_data_i = bp[2];
    step();
    chk("bp_ready_held", 64'(lk.rev_ready_o), 64'd0);
    chk("bp_head_held", 64'(lk.rev_data_o), 64'(bp[0]));
    k = 0;
    lk.rev_ready_i = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      if (lk.rev_v_o) begin
        chk("bp_order", 64'(lk.rev_data_o), 64'(bp[k]));
        k++;
      end
      acc = lk.rev_v_i && lk.rev_ready_o;
      step();
      if (acc) lk.rev_v_i = 1'b0;
    end
    chk("bp_drained", 64'(k), 64'd3);
    chk("bp_count", 64'(lk.rev_count_o), 64'd3);
    chk("bp_idle", 64'(lk.idle_o), 64'd1);
    exp_rev_cnt = 3;
    lk.rev_ready_i = 1'b0;

    // Streaming: one forward packet per cycle for 100 cycles, then drain.
    traffic(100, 100, 100, 0, 0);
    traffic(5, 0, 100, 0, 100);
    chk("stream_count", 64'(lk.fwd_count_o), 64'd101);

    // Random valid/ready on both channels, then drain.
    traffic(10000, 50, 50, 50, 50);
    traffic(20, 0, 100, 0, 100);
    chk("rand_fwd_empty", 64'(fq.size()), 64'd0);
    chk("rand_rev_empty", 64'(rq.size()), 64'd0);

    // Small instance: three-deep fill, pointer wrap, counter saturation at 15.
    ls.fwd_ready_i = 1'b0;
    sent = 0;
    for (int c = 0; c < 3; c++) begin
      chk("sat_fill_ready", 64'(ls.fwd_ready_o), 64'd1);
      ls.fwd_v_i = 1'b1;
      ls.fwd_data_i = 64'(sent) + 64'h5A00;
      sq.push_back(ls.fwd_data_i);
      sent++;
      step();
    end
    ls.fwd_v_i = 1'b0;
    chk("sat_full_ready", 64'(ls.fwd_ready_o), 64'd0);
    ls.fwd_ready_i = 1'b1;
    for (int c = 0; c < 60 && (sent < 20 || sq.size() != 0); c++) begin
      chk("sat_ready", 64'(ls.fwd_ready_o), 64'(sq.size() < 3));
      if (sent < 20) begin
        ls.fwd_v_i = 1'b1;
        ls.fwd_data_i = 64'(sent) + 64'h5A00;
      end else begin
        ls.fwd_v_i = 1'b0;
      end
      acc = ls.fwd_v_i && (sq.size() < 3);
      if (sq.size() != 0) chk("sat_data", ls.fwd_data_o, sq.pop_front());
      if (acc) begin
        sq.push_back(ls.fwd_data_i);
        sent++;
      end
      step();
    end
    ls.fwd_v_i = 1'b0;
    chk("sat_sent", 64'(sent), 64'd20);
    chk("sat_count", 64'(ls.fwd_count_o), 64'd15);
    chk("sat_idle", 64'(ls.idle_o), 64'd1);

    // Mid-flight reset with both default-instance FIFOs holding two packets.
    lk.fwd_ready_i = 1'b0;
    lk.rev_ready_i = 1'b0;
    lk.fwd_v_i = 1'b1;
    lk.rev_v_i = 1'b1;
    lk.fwd_data_i = 64'h1111_2222_3333_4444;
    lk.rev_data_i = 40'h55_6666_7777;
    repeat (2) step();
    lk.fwd_v_i = 1'b0;
    lk.rev_v_i = 1'b0;
    chk("mid_fwd_v", 64'(lk.fwd_v_o), 64'd1);
    chk("mid_full", 64'(lk.fwd_ready_o), 64'd0);
    reset_n = 1'b0;
    step();
    chk("mid_rst_fwd_v", 64'(lk.fwd_v_o), 64'd0);
    chk("mid_rst_rev_v", 64'(lk.rev_v_o), 64'd0);
    chk("mid_rst_fwd_count", 64'(lk.fwd_count_o), 64'd0);
    chk("mid_rst_sat_count", 64'(ls.fwd_count_o), 64'd0);
    chk("mid_rst_ready", 64'(lk.fwd_ready_o), 64'd0);
    chk("mid_rst_idle", 64'(lk.idle_o), 64'd0);
    chk("mid_rst_data", lk.fwd_data_o, 64'd0);
    reset_n = 1'b1;
    lk.fwd_ready_i = 1'b1;
    lk.rev_ready_i = 1'b1;
    step();
    chk("mid_rel_fwd_v", 64'(lk.fwd_v_o), 64'd0);
    chk("mid_rel_rev_data", 64'(lk.rev_data_o), 64'd0);
    chk("mid_rel_idle", 64'(lk.idle_o), 64'd1);
    chk("mid_rel_ready", 64'(lk.rev_ready_o), 64'd1);
    step();
    chk("mid_no_stale_fwd", 64'(lk.fwd_v_o), 64'd0);
    chk("mid_no_stale_rev", 64'(lk.rev_v_o), 64'd0);
    chk("mid_rel_count", 64'(lk.rev_count_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
